// File: rtl/li_mem_responder.sv
// Target-side word bank for the logarithmic interconnect.
// Adds wait states, stall and a preload port to exercise initiator stall paths.
module li_mem_responder #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned WaitWidth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 li_req_i,
    input  logic                 li_we_i,
    input  logic [AddrWidth-1:0] li_addr_i,
    input  logic [DataWidth-1:0] li_wdata_i,
    output logic                 li_gnt_o,
    output logic                 li_rvalid_o,
    output logic [DataWidth-1:0] li_rdata_o,
    input  logic [WaitWidth-1:0] cfg_wait_i,
    input  logic                 stall_i,
    input  logic                 init_we_i,
    input  logic [AddrWidth-1:0] init_addr_i,
    input  logic [DataWidth-1:0] init_wdata_i,
    output logic                 err_o
);

    localparam int unsigned IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [AddrWidth:0] Limit = (AddrWidth+1)'(NumWords);

    logic [DataWidth-1:0] r_mem [NumWords];
    logic [WaitWidth-1:0] r_cnt;
    logic                 r_rvalid;
    logic [DataWidth-1:0] r_rdata;
    logic                 r_err;

    logic                 w_addr_ok;
    logic                 w_init_ok;
    logic                 w_wait_done;
    logic                 w_gnt;
    logic [IdxW-1:0]      w_li_idx;
    logic [IdxW-1:0]      w_init_idx;

    assign w_addr_ok   = {1'b0, li_addr_i} < Limit;
    assign w_init_ok   = {1'b0, init_addr_i} < Limit;
    assign w_wait_done = r_cnt >= cfg_wait_i;
    assign w_li_idx    = li_addr_i[IdxW-1:0];
    assign w_init_idx  = init_addr_i[IdxW-1:0];

    // Preload and clear both take the cycle away from the LI port.
    assign w_gnt = li_req_i & w_addr_ok & w_wait_done
                 & ~stall_i & ~init_we_i & ~clear_i;

    assign li_gnt_o    = w_gnt;
    assign li_rvalid_o = r_rvalid;
    assign li_rdata_o  = r_rdata;
    assign err_o       = r_err;

    // Wait counter: restarts on idle, clear or grant; saturates while blocked.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (!li_req_i || clear_i || w_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Response path: one-cycle rvalid after any grant, rdata on reads only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_gnt && !li_we_i) begin
                r_rdata <= r_mem[w_li_idx];
            end
        end
    end

    // Sticky error for requests that target a non-existent word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (clear_i) begin
            r_err <= 1'b0;
        end else if (li_req_i && !w_addr_ok) begin
            r_err <= 1'b1;
        end
    end

    // Single write port: preload wins, out-of-range preloads are dropped.
    always_ff @(posedge clk_i) begin
        if (init_we_i) begin
            if (w_init_ok) begin
                r_mem[w_init_idx] <= init_wdata_i;
            end
        end else if (w_gnt && li_we_i) begin
            r_mem[w_li_idx] <= li_wdata_i;
        end
    end

endmodule

// File: tb/tb_li_mem_responder.sv
// Directed bench for li_mem_responder.
// Responses are checked by a scoreboard monitor decoupled from stimulus.
module tb_li_mem_responder;

    typedef struct {
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [3:0]  cfg = '0;
    logic        stall = 1'b0;
    logic        init_we = 1'b0;
    logic [15:0] init_addr = '0;
    logic [31:0] init_wdata = '0;
    logic        err;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [31:0] exp_mem [8];
    logic prev_gnt = 1'b0;

    li_mem_responder dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .li_req_i    (req),
        .li_we_i     (we),
        .li_addr_i   (addr),
        .li_wdata_i  (wdata),
        .li_gnt_o    (gnt),
        .li_rvalid_o (rvalid),
        .li_rdata_o  (rdata),
        .cfg_wait_i  (cfg),
        .stall_i     (stall),
        .init_we_i   (init_we),
        .init_addr_i (init_addr),
        .init_wdata_i(init_wdata),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: rvalid must mirror last cycle's grant,
    // and every response is matched against the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_gnt = 1'b0;
        end else begin
            chk("rvalid_follows_gnt", {31'b0, rvalid}, {31'b0, prev_gnt});
            if (rvalid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.rd) chk("rdata", rdata, e.data);
                end
            end
            prev_gnt = gnt;
        end
    end

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        init_we = 1'b1; init_addr = a; init_wdata = d;
        @(posedge clk); #1;
        init_we = 1'b0;
    endtask

    task automatic li_access(input logic w, input logic [15:0] a,
                             input logic [31:0] d, output int waited);
        bit got;
        got = 0;
        waited = 0;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (gnt) begin
                got = 1;
                break;
            end
            waited++;
            @(posedge clk); #1;
        end
        if (!got) chk("gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    initial begin
        int waited;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_gnt", {31'b0, gnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            exp_mem[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0011;
            preload(16'(i), exp_mem[i]);
        end
        preload(16'd2000, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("oob_preload_no_err", {31'b0, err}, 32'd0);

        // 1: preload then zero-wait read
        preload(16'd5, 32'hDEAD_BEEF);
        exp_mem[5] = 32'hDEAD_BEEF;
        cfg = 4'd0;
        sb.push_back('{1'b1, 32'hDEAD_BEEF});
        li_access(1'b0, 16'd5, 32'h0, waited);
        chk("t1_wait", 32'(waited), 32'd0);

        // 2: three wait states on write and read-back
        cfg = 4'd3;
        sb.push_back('{1'b0, 32'h0});
        li_access(1'b1, 16'd9, 32'h1234_5678, waited);
        chk("t2_wr_wait", 32'(waited), 32'd3);
        sb.push_back('{1'b1, 32'h1234_5678});
        li_access(1'b0, 16'd9, 32'h0, waited);
        chk("t2_rd_wait", 32'(waited), 32'd3);

        // 3: back-to-back reads
        cfg = 4'd0;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr = 16'(i);
            sb.push_back('{1'b1, exp_mem[i]});
            @(negedge clk);
            chk("t3_gnt", {31'b0, gnt}, 32'd1);
            @(posedge clk); #1;
        end
        req = 1'b0;

        // 4: stall for four cycles, then grant on first free cycle
        cfg = 4'd1;
        @(posedge clk); #1;
        stall = 1'b1; req = 1'b1; we = 1'b0; addr = 16'd3;
        sb.push_back('{1'b1, exp_mem[3]});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_stall_gnt", {31'b0, gnt}, 32'd0);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        chk("t4_unstall_gnt", {31'b0, gnt}, 32'd1);
        @(posedge clk); #1;
        req = 1'b0;

        // 4b: dropped request yields nothing and restarts the wait
        cfg = 4'd3;
        @(posedge clk); #1;
        req = 1'b1; addr = 16'd4;
        @(negedge clk);
        chk("t4_drop_gnt0", {31'b0, gnt}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_drop_gnt1", {31'b0, gnt}, 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        repeat (4) @(posedge clk);
        sb.push_back('{1'b0, 32'h0});
        li_access(1'b1, 16'd4, 32'h4444_0004, waited);
        exp_mem[4] = 32'h4444_0004;
        chk("t4_after_drop_wait", 32'(waited), 32'd3);

        // 5: invalid address, sticky error, clear
        cfg = 4'd0;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 16'd1024;
        @(negedge clk);
        chk("t5_gnt", {31'b0, gnt}, 32'd0);
        chk("t5_err_pre", {31'b0, err}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_err_set", {31'b0, err}, 32'd1);
        chk("t5_gnt2", {31'b0, gnt}, 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("t5_err_sticky", {31'b0, err}, 32'd1);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("t5_err_clr", {31'b0, err}, 32'd0);

        // 5b: clear with request held restarts the wait count
        cfg = 4'd5;
        sb.push_back('{1'b1, exp_mem[6]});
        @(posedge clk); #1;
        req = 1'b1; addr = 16'd6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_hold_gnt", {31'b0, gnt}, 32'd0);
            @(posedge clk); #1;
        end
        clear = 1'b1;
        @(negedge clk);
        chk("t5_clear_gnt", {31'b0, gnt}, 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        waited = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt) break;
            waited++;
            @(posedge clk); #1;
        end
        chk("t5_cnt_restart", 32'(waited), 32'd5);
        @(posedge clk); #1;
        req = 1'b0;

        // 6: preload collides with LI write, LI write lands later
        cfg = 4'd0;
        @(posedge clk); #1;
        init_we = 1'b1; init_addr = 16'd2; init_wdata = 32'hAAAA_5555;
        req = 1'b1; we = 1'b1; addr = 16'd2; wdata = 32'h0BAD_F00D;
        sb.push_back('{1'b0, 32'h0});
        @(negedge clk);
        chk("t6_gnt_deferred", {31'b0, gnt}, 32'd0);
        @(posedge clk); #1;
        init_we = 1'b0;
        @(negedge clk);
        chk("t6_gnt", {31'b0, gnt}, 32'd1);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        sb.push_back('{1'b1, 32'h0BAD_F00D});
        li_access(1'b0, 16'd2, 32'h0, waited);
        chk("t6_rd_wait", 32'(waited), 32'd0);

        // 6b: reset while waiting
        @(posedge clk); #1;
        req = 1'b1; addr = 16'd2000;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("t6_err_before_rst", {31'b0, err}, 32'd1);
        cfg = 4'd4;
        @(posedge clk); #1;
        req = 1'b1; addr = 16'd1;
        @(negedge clk);
        chk("t6_wait_gnt0", {31'b0, gnt}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_wait_gnt1", {31'b0, gnt}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("t6_rst_err", {31'b0, err}, 32'd0);
        chk("t6_rst_rdata", rdata, 32'h0);
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
